grid_arbiter: RTL
=================

GRID_ARBITER -- requirements
Module: grid_arbiter

Interface
REQ-001 Parameter: NREQ, 3, number of requesters (index 0 = enemy updater, 1 = player/bullet updater, 2 = renderer).
REQ-002 Parameter: MAX_X, 39, largest legal grid column.
REQ-003 Parameter: MAX_Y, 29, largest legal grid row.
REQ-004 Parameter: MAX_HOLD, 4096, maximum consecutive cycles one requester may hold the grant.
REQ-005 Port: clock  in  1  single clock, rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: req  in  3  per-requester request; held high for the whole multi-cycle transaction.
REQ-008 Port: req_x  in  18  packed 3x6 column addresses, requester i at bits [6i+5:6i].
REQ-009 Port: req_y  in  15  packed 3x5 row addresses.
REQ-010 Port: req_write  in  3  per-requester write enable.
REQ-011 Port: req_in  in  9  packed 3x3 write data.
REQ-012 Port: gnt  out  3  one-hot or zero grant, registered.
REQ-013 Port: rd_data  out  3  grid read data broadcast to all requesters.
REQ-014 Port: rd_valid  out  3  per-requester pulse: rd_data holds the result of that requester's read from the previous cycle.
REQ-015 Port: grid_x  out  6; grid_y  out  5; grid_write  out  1; grid_in  out  3  shared grid port.
REQ-016 Port: grid_out  in  3  grid memory read data, valid one cycle after the address is presented.
REQ-017 Port: err_timeout  out  1; err_oob  out  1  single-cycle error pulses.

Function
REQ-018 States: IDLE (no owner), OWN (gnt one-hot), HANDOFF (one dead cycle after release).
REQ-019 IDLE, any req high: at the next edge grant the first requesting index found by scanning round-robin from (last_owner+1) mod 3, then go to OWN; with no req, stay in IDLE.
REQ-020 OWN: the grid port is driven combinationally from the owner's req_x/req_y/req_write/req_in.
REQ-021 OWN, owner drops req: gnt cleared at the next edge, then HANDOFF.
REQ-022 HANDOFF lasts exactly 1 cycle and then goes to IDLE; requests are evaluated again in IDLE.
REQ-023 When not in OWN: grid_write=0, and grid_x, grid_y, grid_in hold 0.
REQ-024 A write with req_x>MAX_X or req_y>MAX_Y is suppressed (grid_write=0) and pulses err_oob in the same cycle; reads are passed through unchanged.
REQ-025 rd_valid[i] is registered and is 1 the cycle after a cycle in which i owned the port with req_write[i]=0; rd_data equals grid_out combinationally.
REQ-026 Hold counter: cleared on grant and incremented every OWN cycle; on reaching MAX_HOLD-1 the grant is revoked at the next edge, err_timeout pulses 1 cycle, and the state goes to HANDOFF.
REQ-027 A revoked requester is skipped in the next arbitration while its req stays high.
REQ-028 Requests raised in the same cycle as a release wait until IDLE; a grant is never issued in HANDOFF.
REQ-029 last_owner updates only on grant issue.

Reset
REQ-030 Asynchronous reset forces IDLE, gnt=0, rd_valid=0, err pulses=0, hold counter=0, and last_owner=2 (so index 0 has first priority).
REQ-031 Reset asserted mid-transaction drops the grant immediately and suppresses grid_write in the same cycle.

Structure
REQ-032 The shared grid package holds GRID_X_W=6, GRID_Y_W=5, CELL_W=3, MAX_X, MAX_Y, and the cell codes (0 air, 4 enemy).
REQ-033 The round-robin pick logic is one sub-module, rr_pick3 (req, last_owner, skip mask -> one-hot), and is combinational.

Verification
REQ-034 req=3'b111 from reset -> gnt 001, then 010, then 100 on successive transactions; each release is followed by 1 HANDOFF cycle with gnt=0.
REQ-035 Owner 0 reads (5,7), grid_out=4 -> rd_valid=001 next cycle with rd_data=4; rd_valid[1] and rd_valid[2] stay 0.
REQ-036 Owner 1 writes x=40, y=3, data=4 -> grid_write=0 and err_oob=1 for that cycle.
REQ-037 Owner 2 holds req for 5000 cycles -> grant revoked after 4096 OWN cycles, err_timeout pulses once, and requester 0 or 1 (if requesting) is granted next.
REQ-038 Reset asserted while owner 0 is writing -> gnt=0 and grid_write=0 with no clock edge; after reset release with req=010, gnt=010 one edge later.

Source files
------------

// File: rtl/grid_arbiter_pkg.sv
// Shared grid definitions: coordinate/cell widths, legal grid bounds, cell codes
// and the arbiter state encoding.
package grid_arbiter_pkg;

  localparam int unsigned GRID_X_W = 6;
  localparam int unsigned GRID_Y_W = 5;
  localparam int unsigned CELL_W   = 3;
  localparam int unsigned MAX_X    = 39;
  localparam int unsigned MAX_Y    = 29;

  typedef enum logic [CELL_W-1:0] {
    CELL_AIR   = 3'd0,
    CELL_ENEMY = 3'd4
  } cell_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN,
    ST_HANDOFF
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    if (oh[2])      return 2'd2;
    else if (oh[1]) return 2'd1;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/grid_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters, scanning from
// (last_owner+1) mod 3 and avoiding skipped requesters where possible.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] last_owner,
  input  logic [2:0] skip,
  output logic [2:0] pick
);

  logic [2:0] cand;
  logic [1:0] idx;

  always_comb begin
    // A skipped requester still wins when it is the only one asking, so a
    // lone revoked requester cannot deadlock the grid.
    cand = ((req & ~skip) != '0) ? (req & ~skip) : req;
    pick = '0;
    idx  = (last_owner >= 2'd2) ? 2'd0 : last_owner + 2'd1;
    for (int unsigned k = 0; k < 3; k++) begin
      if (pick == '0 && cand[idx]) begin
        pick[idx] = 1'b1;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

endmodule

// File: rtl/grid_arbiter.sv
// Round-robin arbiter sharing one grid memory port between three updaters,
// with a hold-time limit, out-of-bounds write suppression and read-valid pulses.
module grid_arbiter
  import grid_arbiter_pkg::*;
#(
  parameter int unsigned NREQ     = 3,
  parameter int unsigned MAX_X    = grid_arbiter_pkg::MAX_X,
  parameter int unsigned MAX_Y    = grid_arbiter_pkg::MAX_Y,
  parameter int unsigned MAX_HOLD = 4096
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*GRID_X_W-1:0]   req_x,
  input  logic [NREQ*GRID_Y_W-1:0]   req_y,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*CELL_W-1:0]     req_in,
  output logic [NREQ-1:0]            gnt,
  output logic [CELL_W-1:0]          rd_data,
  output logic [NREQ-1:0]            rd_valid,
  output logic [GRID_X_W-1:0]        grid_x,
  output logic [GRID_Y_W-1:0]        grid_y,
  output logic                       grid_write,
  output logic [CELL_W-1:0]          grid_in,
  input  logic [CELL_W-1:0]          grid_out,
  output logic                       err_timeout,
  output logic                       err_oob
);

  localparam int unsigned            HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0]      HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [GRID_X_W-1:0]    X_LIMIT   = GRID_X_W'(MAX_X);
  localparam logic [GRID_Y_W-1:0]    Y_LIMIT   = GRID_Y_W'(MAX_Y);

  arb_state_t          state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     skip_q, skip_d;
  logic [NREQ-1:0]     rd_valid_q, rd_valid_d;
  logic [1:0]          last_owner_q, last_owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                err_timeout_q, err_timeout_d;

  logic [NREQ-1:0]     pick;
  logic                owner_req;
  logic                active;
  logic                oob;
  logic [GRID_X_W-1:0] own_x;
  logic [GRID_Y_W-1:0] own_y;
  logic                own_w;
  logic [CELL_W-1:0]   own_in;

  rr_pick3 u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .skip       (skip_q),
    .pick       (pick)
  );

  always_comb begin
    own_x  = '0;
    own_y  = '0;
    own_w  = 1'b0;
    own_in = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        own_x  = req_x[i*GRID_X_W +: GRID_X_W];
        own_y  = req_y[i*GRID_Y_W +: GRID_Y_W];
        own_w  = req_write[i];
        own_in = req_in[i*CELL_W +: CELL_W];
      end
    end
  end

  // Gating on reset as well keeps the grid write dead during reset even
  // before the asynchronously cleared state has propagated.
  always_comb begin
    owner_req  = |(req & gnt_q);
    active     = (state_q == ST_OWN) && !reset;
    oob        = own_w && ((own_x > X_LIMIT) || (own_y > Y_LIMIT));
    grid_x     = active ? own_x  : '0;
    grid_y     = active ? own_y  : '0;
    grid_in    = active ? own_in : '0;
    grid_write = active && own_w && !oob;
    err_oob    = active && oob;
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_owner_d  = last_owner_q;
    hold_d        = hold_q;
    skip_d        = skip_q & req;
    err_timeout_d = 1'b0;
    rd_valid_d    = (state_q == ST_OWN) ? (gnt_q & ~req_write) : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (req != '0) begin
          gnt_d        = pick;
          last_owner_d = onehot_to_idx(pick);
          hold_d       = '0;
          skip_d       = '0;
          state_d      = ST_OWN;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = ST_HANDOFF;
        end else if (hold_q == HOLD_LAST) begin
          gnt_d         = '0;
          skip_d        = gnt_q;
          err_timeout_d = 1'b1;
          state_d       = ST_HANDOFF;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_HANDOFF: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      skip_q        <= '0;
      rd_valid_q    <= '0;
      last_owner_q  <= 2'd2;
      hold_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      skip_q        <= skip_d;
      rd_valid_q    <= rd_valid_d;
      last_owner_q  <= last_owner_d;
      hold_q        <= hold_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign rd_valid    = rd_valid_q;
  assign err_timeout = err_timeout_q;
  assign rd_data     = grid_out;

endmodule
